// File: rtl/vending_checkout_pkg.sv
// Shared widths, product count and alert encodings for the vending checkout slice.
package vending_pkg;

   localparam int unsigned NUM_PRODUCTS = 8;
   localparam int unsigned PID_W        = 3;
   localparam int unsigned PRICE_W      = 8;
   localparam int unsigned QTY_W        = 4;
   localparam int unsigned MONEY_W      = 16;
   localparam int unsigned STOCK_W      = 4;

   localparam logic [1:0] ALERT_OK    = 2'b00;
   localparam logic [1:0] ALERT_LOW   = 2'b01;
   localparam logic [1:0] ALERT_EMPTY = 2'b10;

endpackage

// File: rtl/vending_checkout_if.sv
// Purchase request / pricing response bus between the front panel and the checkout.
interface vending_checkout_if;
   import vending_pkg::*;

   logic [PID_W-1:0]   product_id;
   logic [PRICE_W-1:0] price0;
   logic [PRICE_W-1:0] price1;
   logic [PRICE_W-1:0] price2;
   logic [PRICE_W-1:0] price3;
   logic [PRICE_W-1:0] price4;
   logic [PRICE_W-1:0] price5;
   logic [PRICE_W-1:0] price6;
   logic [PRICE_W-1:0] price7;
   logic [QTY_W-1:0]   quantity;
   logic [MONEY_W-1:0] amount_paid;

   logic [PRICE_W-1:0] price;
   logic [MONEY_W-1:0] total_price;
   logic               discount;
   logic [MONEY_W-1:0] discounted_price;
   logic [MONEY_W-1:0] remaining_amount;
   logic               accept;

   // Front panel side: issues the request, observes the pricing result.
   modport master (
      output product_id, price0, price1, price2, price3, price4, price5, price6, price7,
      output quantity, amount_paid,
      input  price, total_price, discount, discounted_price, remaining_amount, accept
   );

   // Checkout side: consumes the request, produces the pricing result.
   modport slave (
      input  product_id, price0, price1, price2, price3, price4, price5, price6, price7,
      input  quantity, amount_paid,
      output price, total_price, discount, discounted_price, remaining_amount, accept
   );

endinterface

// File: rtl/vending_checkout_stock_alert.sv
// Maps one product's stock level to its 2-bit status (ok / low / empty).
module vc_stock_alert
   import vending_pkg::*;
#(
   parameter logic [STOCK_W-1:0] LOW_THRESH = 4'd3
) (
   input  logic [STOCK_W-1:0] stock,
   output logic [1:0]         alert
);

   // Empty takes priority over low; 2'b11 is unreachable.
   always_comb begin
      alert = ALERT_OK;
      if (stock == '0)
         alert = ALERT_EMPTY;
      else if (stock <= LOW_THRESH)
         alert = ALERT_LOW;
   end

endmodule

// File: rtl/vending_checkout.sv
// Vending checkout: combinational pricing/discount/change, registered per-product
// stock with low-stock alerts. Optional sales accumulator enabled by the macro
// VENDING_SALES_REGISTER_EN (default: sales_total tied to zero).
module vending_checkout
   import vending_pkg::*;
#(
   parameter logic [STOCK_W-1:0] INIT_STOCK   = 4'd15,
   parameter logic [QTY_W-1:0]   DISCOUNT_QTY = 4'd10,
   parameter logic [STOCK_W-1:0] LOW_THRESH   = 4'd3
) (
   input  logic               clk,
   input  logic               reset,
   vending_checkout_if.slave  bus,
   output logic [STOCK_W-1:0] stock0,
   output logic [STOCK_W-1:0] stock1,
   output logic [STOCK_W-1:0] stock2,
   output logic [STOCK_W-1:0] stock3,
   output logic [STOCK_W-1:0] stock4,
   output logic [STOCK_W-1:0] stock5,
   output logic [STOCK_W-1:0] stock6,
   output logic [STOCK_W-1:0] stock7,
   output logic [1:0]         alert0,
   output logic [1:0]         alert1,
   output logic [1:0]         alert2,
   output logic [1:0]         alert3,
   output logic [1:0]         alert4,
   output logic [1:0]         alert5,
   output logic [1:0]         alert6,
   output logic [1:0]         alert7,
   output logic [MONEY_W-1:0] sales_total
);

   logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];
   logic [1:0]         alert_w [NUM_PRODUCTS];
   logic [PRICE_W-1:0] unit_price;
   logic [STOCK_W-1:0] sel_stock;
   logic [MONEY_W-1:0] total;
   logic [MONEY_W-1:0] due;
   logic               disc;
   logic               paid_enough;
   logic               accept_w;

   // Unit price mux on the selected product.
   always_comb begin
      unit_price = bus.price0;
      case (bus.product_id)
         3'd0: unit_price = bus.price0;
         3'd1: unit_price = bus.price1;
         3'd2: unit_price = bus.price2;
         3'd3: unit_price = bus.price3;
         3'd4: unit_price = bus.price4;
         3'd5: unit_price = bus.price5;
         3'd6: unit_price = bus.price6;
         3'd7: unit_price = bus.price7;
         default: unit_price = bus.price0;
      endcase
   end

   // Total, bulk discount (truncating 10%), saturating change and acceptance.
   always_comb begin
      sel_stock   = stock_q[bus.product_id];
      total       = MONEY_W'(unit_price) * MONEY_W'(bus.quantity);
      disc        = (bus.quantity >= DISCOUNT_QTY);
      due         = disc ? (total - (total / 16'd10)) : total;
      paid_enough = (bus.amount_paid >= due);
      accept_w    = (bus.quantity != '0) && (bus.quantity <= sel_stock) && paid_enough;
   end

   assign bus.price            = unit_price;
   assign bus.total_price      = total;
   assign bus.discount         = disc;
   assign bus.discounted_price = due;
   assign bus.remaining_amount = paid_enough ? (bus.amount_paid - due) : '0;
   assign bus.accept           = accept_w;

   // Stock registers: every accepted edge consumes the requested quantity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_PRODUCTS; i++)
            stock_q[i] <= INIT_STOCK;
      end else if (accept_w) begin
         stock_q[bus.product_id] <= sel_stock - bus.quantity;
      end
   end

   for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_alert
      vc_stock_alert #(.LOW_THRESH(LOW_THRESH)) u_alert (
         .stock (stock_q[g]),
         .alert (alert_w[g])
      );
   end

   assign stock0 = stock_q[0];
   assign stock1 = stock_q[1];
   assign stock2 = stock_q[2];
   assign stock3 = stock_q[3];
   assign stock4 = stock_q[4];
   assign stock5 = stock_q[5];
   assign stock6 = stock_q[6];
   assign stock7 = stock_q[7];

   assign alert0 = alert_w[0];
   assign alert1 = alert_w[1];
   assign alert2 = alert_w[2];
   assign alert3 = alert_w[3];
   assign alert4 = alert_w[4];
   assign alert5 = alert_w[5];
   assign alert6 = alert_w[6];
   assign alert7 = alert_w[7];

`ifdef VENDING_SALES_REGISTER_EN
   logic [MONEY_W-1:0] sales_q;

   // Running sales sum of amounts due, wrapping modulo 2^16.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sales_q <= '0;
      else if (accept_w)
         sales_q <= sales_q + due;
   end

   assign sales_total = sales_q;
`else
   assign sales_total = '0;
`endif

endmodule

// File: tb/tb_vending_checkout.sv
// Self-checking bench for vending_checkout: behavioural model + per-cycle compare,
// plus directed vectors with hand-computed expectations.
module tb_vending_checkout;
   import vending_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vending_checkout_if vif ();

   logic [3:0]  stock0, stock1, stock2, stock3, stock4, stock5, stock6, stock7;
   logic [1:0]  alert0, alert1, alert2, alert3, alert4, alert5, alert6, alert7;
   logic [15:0] sales_total;

   vending_checkout #(
      .INIT_STOCK   (4'd15),
      .DISCOUNT_QTY (4'd10),
      .LOW_THRESH   (4'd3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (vif),
      .stock0      (stock0), .stock1 (stock1), .stock2 (stock2), .stock3 (stock3),
      .stock4      (stock4), .stock5 (stock5), .stock6 (stock6), .stock7 (stock7),
      .alert0      (alert0), .alert1 (alert1), .alert2 (alert2), .alert3 (alert3),
      .alert4      (alert4), .alert5 (alert5), .alert6 (alert6), .alert7 (alert7),
      .sales_total (sales_total)
   );

   logic [3:0] st [8];
   logic [1:0] al [8];
   assign st[0] = stock0; assign st[1] = stock1; assign st[2] = stock2; assign st[3] = stock3;
   assign st[4] = stock4; assign st[5] = stock5; assign st[6] = stock6; assign st[7] = stock7;
   assign al[0] = alert0; assign al[1] = alert1; assign al[2] = alert2; assign al[3] = alert3;
   assign al[4] = alert4; assign al[5] = alert5; assign al[6] = alert6; assign al[7] = alert7;

   int tests = 0;
   int fails = 0;
   bit done  = 1'b0;

   int prices [8] = '{10, 20, 30, 40, 50, 60, 70, 80};
   int cur_pid  = 0;
   int cur_qty  = 0;
   int cur_paid = 0;

   int m_stock [8] = '{15, 15, 15, 15, 15, 15, 15, 15};
   int m_sales = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_total();
      return prices[cur_pid] * cur_qty;
   endfunction

   function automatic int m_disc();
      return (cur_qty >= 10) ? 1 : 0;
   endfunction

   function automatic int m_due();
      int t;
      t = m_total();
      return (m_disc() != 0) ? (t - t / 10) : t;
   endfunction

   function automatic int m_change();
      return (cur_paid >= m_due()) ? (cur_paid - m_due()) : 0;
   endfunction

   function automatic int m_accept();
      return (cur_qty != 0 && cur_qty <= m_stock[cur_pid] && cur_paid >= m_due()) ? 1 : 0;
   endfunction

   function automatic int m_alert(input int s);
      if (s == 0) return 2;
      if (s <= 3) return 1;
      return 0;
   endfunction

   function automatic int m_sales_exp();
`ifdef VENDING_SALES_REGISTER_EN
      return m_sales;
`else
      return 0;
`endif
   endfunction

   // Model state advances on the same events as the design.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) m_stock[i] <= 15;
         m_sales <= 0;
      end else if (m_accept() != 0) begin
         m_stock[cur_pid] <= m_stock[cur_pid] - cur_qty;
         m_sales          <= (m_sales + m_due()) % 65536;
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      if (!done) begin
         check("price",     int'(vif.price),            prices[cur_pid]);
         check("total",     int'(vif.total_price),      m_total());
         check("discount",  int'(vif.discount),         m_disc());
         check("due",       int'(vif.discounted_price), m_due());
         check("change",    int'(vif.remaining_amount), m_change());
         check("accept",    int'(vif.accept),           m_accept());
         for (int i = 0; i < 8; i++) begin
            check($sformatf("stock%0d", i), int'(st[i]), m_stock[i]);
            check($sformatf("alert%0d", i), int'(al[i]), m_alert(m_stock[i]));
         end
         check("sales", int'(sales_total), m_sales_exp());
      end
   end

   task automatic drive(input int pid, input int qty, input int paid);
      cur_pid  = pid;
      cur_qty  = qty;
      cur_paid = paid;
      vif.product_id  = 3'(pid);
      vif.quantity    = 4'(qty);
      vif.amount_paid = 16'(paid);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_pricing(input string tag, input int pr, input int tot, input int dsc,
                                input int due, input int chg, input int acc);
      check({tag, "_price"},  int'(vif.price),            pr);
      check({tag, "_total"},  int'(vif.total_price),      tot);
      check({tag, "_disc"},   int'(vif.discount),         dsc);
      check({tag, "_due"},    int'(vif.discounted_price), due);
      check({tag, "_change"}, int'(vif.remaining_amount), chg);
      check({tag, "_accept"}, int'(vif.accept),           acc);
   endtask

   initial begin
      vif.price0 = 8'(prices[0]); vif.price1 = 8'(prices[1]);
      vif.price2 = 8'(prices[2]); vif.price3 = 8'(prices[3]);
      vif.price4 = 8'(prices[4]); vif.price5 = 8'(prices[5]);
      vif.price6 = 8'(prices[6]); vif.price7 = 8'(prices[7]);
      drive(0, 0, 0);
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("rst_stock%0d", i), int'(st[i]), 15);
         check($sformatf("rst_alert%0d", i), int'(al[i]), 0);
      end
      check("rst_sales", int'(sales_total), 0);

      drive(1, 5, 250);
      #1 check_pricing("p1", 20, 100, 0, 100, 150, 1);
      step();
      check("p1_stock1", int'(stock1), 10);

      drive(2, 10, 350);
      #1 check_pricing("p2", 30, 300, 1, 270, 80, 1);
      step();
      check("p2_stock2", int'(stock2), 5);
      check("p2_alert2", int'(alert2), 0);
      check("p2_hold_accept", int'(vif.accept), 0);
      step();
      check("p2_hold_stock2", int'(stock2), 5);

      drive(3, 12, 450);
      #1 check_pricing("p3", 40, 480, 1, 432, 18, 1);
      step();
      check("p3_stock3", int'(stock3), 3);
      check("p3_alert3", int'(alert3), 1);
`ifdef VENDING_SALES_REGISTER_EN
      check("p3_sales", int'(sales_total), 802);
`endif

      drive(3, 3, 200);
      #1 check_pricing("p3b", 40, 120, 0, 120, 80, 1);
      step();
      check("p3b_stock3", int'(stock3), 0);
      check("p3b_alert3", int'(alert3), 2);

      drive(4, 15, 550);
      #1 check_pricing("p4", 50, 750, 1, 675, 0, 0);
      step();
      check("p4_stock4", int'(stock4), 15);

      drive(0, 0, 100);
      #1 check("q0_accept", int'(vif.accept), 0);
      step();
      check("q0_stock0", int'(stock0), 15);

      drive(0, 1, 0);
      #1 check_pricing("nopay", 10, 10, 0, 10, 0, 0);

      drive(0, 2, 65535);
      #1 check_pricing("p0", 10, 20, 0, 20, 65515, 1);
      step();
      step();
      check("p0_stock0", int'(stock0), 11);

      drive(0, 12, 65535);
      #1 check("p0_short_accept", int'(vif.accept), 0);
      step();
      check("p0_short_stock0", int'(stock0), 11);

      drive(5, 15, 65535);
      #1 check_pricing("p5", 60, 900, 1, 810, 64725, 1);
      step();
      check("p5_stock5", int'(stock5), 0);
      check("p5_alert5", int'(alert5), 2);
      drive(5, 1, 65535);
      #1 check("p5_empty_accept", int'(vif.accept), 0);
`ifdef VENDING_SALES_REGISTER_EN
      check("sales_sum", int'(sales_total), 1772);
`else
      check("sales_tied", int'(sales_total), 0);
`endif

      // Asynchronous reset asserted between edges.
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("arst_stock1", int'(stock1), 15);
      check("arst_stock5", int'(stock5), 15);
      check("arst_alert3", int'(alert3), 0);
      check("arst_sales", int'(sales_total), 0);
      drive(0, 0, 0);
      reset = 1'b0;
      repeat (3) step();
      check("post_stock0", int'(stock0), 15);

      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
